rename_map_table_ss: RTL and testbench
======================================

Name: rename_map_table_ss

Overview:
- Superscalar, checkpointing register rename map table: maps architectural to physical tags with per-entry ready bits.
- Renames up to DISPATCH_WIDTH instructions per cycle, with intra-group dependency bypass.
- Absorbs CDB_WIDTH completions per cycle.
- Keeps NUM_CKPT branch checkpoints for single-cycle rollback. Sits between decode/dispatch and RS/ROB/free list.

Parameters:
NUM_ARCH_REG, 32, architectural registers
PHYS_W, 6, physical tag width
DISPATCH_WIDTH, 2, rename lanes per cycle
CDB_WIDTH, 2, completion broadcast ports
NUM_CKPT, 4, checkpoint slots
ZERO_REG, 31, hardwired-zero register index
CKPT_W, $clog2(NUM_CKPT), checkpoint id width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
en  in  1  state-update enable; outputs stay live when low
disp_valid  in  DISPATCH_WIDTH  lane k renames this cycle
dest_reg  in  DISPATCH_WIDTH x 5  destination per lane
src_a, src_b  in  DISPATCH_WIDTH x 5  sources per lane
new_tag  in  DISPATCH_WIDTH x PHYS_W  free-list tag per lane
ckpt_req  in  DISPATCH_WIDTH  lane k is a branch needing a checkpoint (at most one bit set)
cdb_valid  in  CDB_WIDTH  completion valid
cdb_tag  in  CDB_WIDTH x PHYS_W  completing tags
rollback_en  in  1  mispredict recovery
rollback_id  in  CKPT_W  checkpoint to restore
ckpt_release  in  NUM_CKPT  slots to free (resolved branches or squashed younger ones)
told  out  DISPATCH_WIDTH x PHYS_W  previous mapping of dest_reg
t1, t2  out  DISPATCH_WIDTH x PHYS_W  source tags
t1_ready, t2_ready  out  DISPATCH_WIDTH  source ready
ckpt_id  out  CKPT_W  slot granted to this cycle's ckpt_req
ckpt_avail  out  1  at least one free slot; dispatch must not assert ckpt_req when low

Behaviour:
- Reset: map[i] = {tag i, ready 1}; all checkpoints free; ckpt_avail = 1; ckpt_id = 0.
- Reads are combinational from the registered map; zero-cycle latency.
- Intra-group bypass: lane k source (or told) equal to dest_reg of the youngest valid lane j<k (dest != ZERO_REG) returns new_tag[j] with ready 0, or told = new_tag[j].
- CDB read bypass applies to non-bypassed lookups: tag matching any valid cdb_tag reads ready 1.
- Source ZERO_REG: tag ZERO_REG, ready 1. Dest ZERO_REG: no map write; told = map[ZERO_REG].tag.
- Next state:
  - CDB first: every map and stored-checkpoint entry whose tag matches a valid cdb_tag sets ready. All matches update; no early exit.
  - Then dispatch lanes in order 0..DISPATCH_WIDTH-1: map[dest] = {new_tag, 0}. The later lane wins on equal dest.
- Checkpoint alloc: the granted slot is the lowest-index free slot, driven combinationally on ckpt_id.
  - The snapshot is the map after CDB and lanes 0..k, where k is the requesting lane. Younger lanes in the group are excluded.
  - ckpt_req while ckpt_avail = 0 is illegal; a bench assertion checks it.
- Release: ckpt_release bits free slots at the clock edge. A slot freed this cycle cannot be granted until the next cycle. Release and CDB update of the same slot are harmless.
- Rollback, priority over dispatch:
  - map <= checkpoint[rollback_id], with same-cycle CDB applied.
  - All disp_valid and ckpt_req are ignored that cycle.
  - The rollback slot itself is freed. Younger slots are freed via ckpt_release.
- en = 0: no state changes, including CDB. The caller must hold CDB valid or replay it.
- Reset mid-operation overrides everything on the next edge.

Test Plan:
- Reset, then read r3/r5 -> t1 = 3, t2 = 5, both ready 1; told of r7 = 7.
- Lane0 r1 <- tag 40, lane1 src_a = r1, dest r1 <- tag 41 -> lane1 t1 = 40 ready 0, lane1 told = 40; next cycle map[r1] = 41, ready 0.
- Map[r2] = 40 not ready; cdb_valid = 01, cdb_tag0 = 40 -> same-cycle read ready 1; next cycle map[r2].ready = 1.
- Lane0 r4 <- 42, lane1 branch ckpt_req with r6 <- 43, slot 0 granted.
  - Then rename r4 <- 44, complete 42 on CDB, rollback_en with id 0.
  - Expected: map[r4] = 42 ready 1, map[r6] = 43 ready 0, slot 0 free.
- Allocate 4 checkpoints on consecutive cycles -> ids 0,1,2,3, ckpt_avail = 0.
  - Then release slot 2: ckpt_avail still 0 that cycle, 1 the next; the next grant is id 2.
- Dest ZERO_REG with new_tag 50, then read src ZERO_REG -> tag 31 ready 1; told = 31; map unchanged.

Source files
------------

// File: rtl/rename_map_table_ss.sv
// Superscalar register rename map table with branch checkpoints.
// Maps architectural registers to physical tags, each with a ready bit. Up to
// DISPATCH_WIDTH instructions are renamed per cycle, and a lane can read a
// destination written by an older lane of the same group. CDB_WIDTH completions
// are absorbed per cycle. NUM_CKPT snapshots allow a single-cycle rollback.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   en_i                state-update enable (lookups stay live when low)
//   disp_valid_i        per-lane rename valid
//   dest_reg_i          per-lane architectural destination
//   src_a_i, src_b_i    per-lane architectural sources
//   new_tag_i           per-lane free-list tag
//   ckpt_req_i          per-lane branch checkpoint request (one-hot or zero)
//   cdb_valid_i         per-port completion valid
//   cdb_tag_i           per-port completing tag
//   rollback_en_i       restore the map from checkpoint rollback_id_i
//   rollback_id_i       checkpoint to restore
//   ckpt_release_i      checkpoint slots to free
//   told_o              previous mapping of each lane's destination
//   t1_o, t2_o          source tags per lane
//   t1_ready_o          source A ready per lane
//   t2_ready_o          source B ready per lane
//   ckpt_id_o           slot granted to this cycle's checkpoint request
//   ckpt_avail_o        at least one checkpoint slot is free
module rename_map_table_ss #(
    parameter int unsigned NUM_ARCH_REG   = 32,
    parameter int unsigned PHYS_W         = 6,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned CDB_WIDTH      = 2,
    parameter int unsigned NUM_CKPT       = 4,
    parameter int unsigned ZERO_REG       = 31,
    parameter int unsigned CKPT_W         = $clog2(NUM_CKPT),
    localparam int unsigned AREG_W        = $clog2(NUM_ARCH_REG)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   en_i,
    input  logic [DISPATCH_WIDTH-1:0]              disp_valid_i,
    input  logic [DISPATCH_WIDTH-1:0][AREG_W-1:0]  dest_reg_i,
    input  logic [DISPATCH_WIDTH-1:0][AREG_W-1:0]  src_a_i,
    input  logic [DISPATCH_WIDTH-1:0][AREG_W-1:0]  src_b_i,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_W-1:0]  new_tag_i,
    input  logic [DISPATCH_WIDTH-1:0]              ckpt_req_i,
    input  logic [CDB_WIDTH-1:0]                   cdb_valid_i,
    input  logic [CDB_WIDTH-1:0][PHYS_W-1:0]       cdb_tag_i,
    input  logic                                   rollback_en_i,
    input  logic [CKPT_W-1:0]                      rollback_id_i,
    input  logic [NUM_CKPT-1:0]                    ckpt_release_i,
    output logic [DISPATCH_WIDTH-1:0][PHYS_W-1:0]  told_o,
    output logic [DISPATCH_WIDTH-1:0][PHYS_W-1:0]  t1_o,
    output logic [DISPATCH_WIDTH-1:0][PHYS_W-1:0]  t2_o,
    output logic [DISPATCH_WIDTH-1:0]              t1_ready_o,
    output logic [DISPATCH_WIDTH-1:0]              t2_ready_o,
    output logic [CKPT_W-1:0]                      ckpt_id_o,
    output logic                                   ckpt_avail_o
);

    localparam logic [AREG_W-1:0] ZERO_IDX = AREG_W'(ZERO_REG);
    localparam logic [PHYS_W-1:0] ZERO_TAG = PHYS_W'(ZERO_REG);

    logic [PHYS_W-1:0] map_tag_q  [NUM_ARCH_REG];
    logic [PHYS_W-1:0] map_tag_d  [NUM_ARCH_REG];
    logic              map_rdy_q  [NUM_ARCH_REG];
    logic              map_rdy_d  [NUM_ARCH_REG];
    logic [PHYS_W-1:0] ckpt_tag_q [NUM_CKPT][NUM_ARCH_REG];
    logic [PHYS_W-1:0] ckpt_tag_d [NUM_CKPT][NUM_ARCH_REG];
    logic              ckpt_rdy_q [NUM_CKPT][NUM_ARCH_REG];
    logic              ckpt_rdy_d [NUM_CKPT][NUM_ARCH_REG];
    logic [NUM_CKPT-1:0] ckpt_free_q;
    logic [NUM_CKPT-1:0] ckpt_free_d;

    // True when any valid completion port carries this tag.
    function automatic logic cdb_hit(
        input logic [PHYS_W-1:0]                tag,
        input logic [CDB_WIDTH-1:0]             vld,
        input logic [CDB_WIDTH-1:0][PHYS_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            if (vld[c] && (tags[c] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Lowest-index free slot; the grant only sees slots free before this edge.
    always_comb begin
        ckpt_id_o    = '0;
        ckpt_avail_o = |ckpt_free_q;
        for (int s = NUM_CKPT - 1; s >= 0; s--) begin
            if (ckpt_free_q[s]) begin
                ckpt_id_o = CKPT_W'(s);
            end
        end
    end

    // Lookups: map read with CDB ready bypass, overridden by the youngest older
    // lane writing the same register, overridden by the hardwired zero register.
    always_comb begin
        told_o     = '0;
        t1_o       = '0;
        t2_o       = '0;
        t1_ready_o = '0;
        t2_ready_o = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            t1_o[k]       = map_tag_q[src_a_i[k]];
            t1_ready_o[k] = map_rdy_q[src_a_i[k]]
                          | cdb_hit(map_tag_q[src_a_i[k]], cdb_valid_i, cdb_tag_i);
            t2_o[k]       = map_tag_q[src_b_i[k]];
            t2_ready_o[k] = map_rdy_q[src_b_i[k]]
                          | cdb_hit(map_tag_q[src_b_i[k]], cdb_valid_i, cdb_tag_i);
            told_o[k]     = map_tag_q[dest_reg_i[k]];
            // Ascending j so the youngest older lane is applied last.
            for (int j = 0; j < k; j++) begin
                if (disp_valid_i[j] && (dest_reg_i[j] != ZERO_IDX)) begin
                    if (dest_reg_i[j] == src_a_i[k]) begin
                        t1_o[k]       = new_tag_i[j];
                        t1_ready_o[k] = 1'b0;
                    end
                    if (dest_reg_i[j] == src_b_i[k]) begin
                        t2_o[k]       = new_tag_i[j];
                        t2_ready_o[k] = 1'b0;
                    end
                    if (dest_reg_i[j] == dest_reg_i[k]) begin
                        told_o[k] = new_tag_i[j];
                    end
                end
            end
            if (src_a_i[k] == ZERO_IDX) begin
                t1_o[k]       = ZERO_TAG;
                t1_ready_o[k] = 1'b1;
            end
            if (src_b_i[k] == ZERO_IDX) begin
                t2_o[k]       = ZERO_TAG;
                t2_ready_o[k] = 1'b1;
            end
        end
    end

    // Next state: CDB wakeup, release, then either rollback or in-order rename
    // with the checkpoint snapshot taken right after the requesting lane.
    always_comb begin
        map_tag_d   = map_tag_q;
        map_rdy_d   = map_rdy_q;
        ckpt_tag_d  = ckpt_tag_q;
        ckpt_rdy_d  = ckpt_rdy_q;
        ckpt_free_d = ckpt_free_q | ckpt_release_i;

        for (int r = 0; r < NUM_ARCH_REG; r++) begin
            if (cdb_hit(map_tag_q[r], cdb_valid_i, cdb_tag_i)) begin
                map_rdy_d[r] = 1'b1;
            end
            for (int s = 0; s < NUM_CKPT; s++) begin
                if (cdb_hit(ckpt_tag_q[s][r], cdb_valid_i, cdb_tag_i)) begin
                    ckpt_rdy_d[s][r] = 1'b1;
                end
            end
        end

        if (rollback_en_i) begin
            for (int r = 0; r < NUM_ARCH_REG; r++) begin
                map_tag_d[r] = ckpt_tag_d[rollback_id_i][r];
                map_rdy_d[r] = ckpt_rdy_d[rollback_id_i][r];
            end
            ckpt_free_d[rollback_id_i] = 1'b1;
        end else begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (disp_valid_i[k] && (dest_reg_i[k] != ZERO_IDX)) begin
                    map_tag_d[dest_reg_i[k]] = new_tag_i[k];
                    map_rdy_d[dest_reg_i[k]] = 1'b0;
                end
                if (ckpt_req_i[k] && ckpt_avail_o) begin
                    for (int r = 0; r < NUM_ARCH_REG; r++) begin
                        ckpt_tag_d[ckpt_id_o][r] = map_tag_d[r];
                        ckpt_rdy_d[ckpt_id_o][r] = map_rdy_d[r];
                    end
                    ckpt_free_d[ckpt_id_o] = 1'b0;
                end
            end
        end
    end

    // State registers; identity map with all checkpoints free on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_ARCH_REG; r++) begin
                map_tag_q[r] <= PHYS_W'(r);
                map_rdy_q[r] <= 1'b1;
                for (int s = 0; s < NUM_CKPT; s++) begin
                    ckpt_tag_q[s][r] <= '0;
                    ckpt_rdy_q[s][r] <= 1'b0;
                end
            end
            ckpt_free_q <= '1;
        end else if (en_i) begin
            map_tag_q   <= map_tag_d;
            map_rdy_q   <= map_rdy_d;
            ckpt_tag_q  <= ckpt_tag_d;
            ckpt_rdy_q  <= ckpt_rdy_d;
            ckpt_free_q <= ckpt_free_d;
        end
    end

endmodule

// File: tb/tb_rename_map_table_ss.sv
// Self-checking bench for rename_map_table_ss: directed scenarios followed by
// randomized traffic, compared against an array-level reference model.
module tb_rename_map_table_ss;

    localparam int NAR  = 32;
    localparam int NCK  = 4;
    localparam int DW   = 2;
    localparam int CW   = 2;
    localparam int ZREG = 31;

    logic                 clock;
    logic                 reset;
    logic                 en;
    logic [DW-1:0]        disp_valid;
    logic [DW-1:0][4:0]   dest_reg;
    logic [DW-1:0][4:0]   src_a;
    logic [DW-1:0][4:0]   src_b;
    logic [DW-1:0][5:0]   new_tag;
    logic [DW-1:0]        ckpt_req;
    logic [CW-1:0]        cdb_valid;
    logic [CW-1:0][5:0]   cdb_tag;
    logic                 rollback_en;
    logic [1:0]           rollback_id;
    logic [NCK-1:0]       ckpt_release;
    logic [DW-1:0][5:0]   told;
    logic [DW-1:0][5:0]   t1;
    logic [DW-1:0][5:0]   t2;
    logic [DW-1:0]        t1_ready;
    logic [DW-1:0]        t2_ready;
    logic [1:0]           ckpt_id;
    logic                 ckpt_avail;

    int checks;
    int failures;

    // Reference model state.
    int m_tag [NAR];
    bit m_rdy [NAR];
    int c_tag [NCK][NAR];
    bit c_rdy [NCK][NAR];
    bit c_busy[NCK];
    // Scratch map for the group being renamed this cycle.
    int sc_tag[NAR];
    bit sc_wr [NAR];

    rename_map_table_ss dut (
        .clock          (clock),
        .reset          (reset),
        .en_i           (en),
        .disp_valid_i   (disp_valid),
        .dest_reg_i     (dest_reg),
        .src_a_i        (src_a),
        .src_b_i        (src_b),
        .new_tag_i      (new_tag),
        .ckpt_req_i     (ckpt_req),
        .cdb_valid_i    (cdb_valid),
        .cdb_tag_i      (cdb_tag),
        .rollback_en_i  (rollback_en),
        .rollback_id_i  (rollback_id),
        .ckpt_release_i (ckpt_release),
        .told_o         (told),
        .t1_o           (t1),
        .t2_o           (t2),
        .t1_ready_o     (t1_ready),
        .t2_ready_o     (t2_ready),
        .ckpt_id_o      (ckpt_id),
        .ckpt_avail_o   (ckpt_avail)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit on_cdb(input int tag);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < CW; c++) begin
            if (cdb_valid[c] && (int'(cdb_tag[c]) == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NAR; r++) begin
            m_tag[r] = r;
            m_rdy[r] = 1'b1;
        end
        for (int s = 0; s < NCK; s++) c_busy[s] = 1'b0;
    endtask

    function automatic int lowest_free();
        int id;
        id = 0;
        for (int s = NCK - 1; s >= 0; s--) if (!c_busy[s]) id = s;
        return id;
    endfunction

    function automatic bit any_free();
        bit f;
        f = 1'b0;
        for (int s = 0; s < NCK; s++) if (!c_busy[s]) f = 1'b1;
        return f;
    endfunction

    // Source lookup against the scratch map: renamed-in-group entries are
    // in flight, everything else reads the committed map plus CDB wakeup.
    task automatic lookup(input int src, output int tag, output bit rdy);
        if (src == ZREG) begin
            tag = ZREG;
            rdy = 1'b1;
        end else if (sc_wr[src]) begin
            tag = sc_tag[src];
            rdy = 1'b0;
        end else begin
            tag = m_tag[src];
            rdy = m_rdy[src] | on_cdb(m_tag[src]);
        end
    endtask

    task automatic check_outputs();
        int e_tag;
        bit e_rdy;
        int e_told;
        for (int r = 0; r < NAR; r++) begin
            sc_tag[r] = m_tag[r];
            sc_wr[r]  = 1'b0;
        end
        for (int k = 0; k < DW; k++) begin
            lookup(int'(src_a[k]), e_tag, e_rdy);
            chk($sformatf("t1[%0d]", k), 32'(t1[k]), 32'(e_tag));
            chk($sformatf("t1_ready[%0d]", k), 32'(t1_ready[k]), 32'(e_rdy));
            lookup(int'(src_b[k]), e_tag, e_rdy);
            chk($sformatf("t2[%0d]", k), 32'(t2[k]), 32'(e_tag));
            chk($sformatf("t2_ready[%0d]", k), 32'(t2_ready[k]), 32'(e_rdy));
            e_told = (int'(dest_reg[k]) == ZREG) ? m_tag[ZREG] : sc_tag[dest_reg[k]];
            chk($sformatf("told[%0d]", k), 32'(told[k]), 32'(e_told));
            if (disp_valid[k] && (int'(dest_reg[k]) != ZREG)) begin
                sc_tag[dest_reg[k]] = int'(new_tag[k]);
                sc_wr[dest_reg[k]]  = 1'b1;
            end
        end
        chk("ckpt_avail", 32'(ckpt_avail), 32'(any_free()));
        chk("ckpt_id", 32'(ckpt_id), 32'(lowest_free()));
        if ((|ckpt_req) && !rollback_en) chk("ckpt_req_legal", 32'(ckpt_avail), 32'd1);
    endtask

    task automatic model_edge();
        bit avail;
        int slot;
        if (reset) begin
            model_reset();
            return;
        end
        if (!en) return;
        avail = any_free();
        slot  = lowest_free();
        for (int r = 0; r < NAR; r++) begin
            if (on_cdb(m_tag[r])) m_rdy[r] = 1'b1;
            for (int s = 0; s < NCK; s++) if (on_cdb(c_tag[s][r])) c_rdy[s][r] = 1'b1;
        end
        for (int s = 0; s < NCK; s++) if (ckpt_release[s]) c_busy[s] = 1'b0;
        if (rollback_en) begin
            for (int r = 0; r < NAR; r++) begin
                m_tag[r] = c_tag[rollback_id][r];
                m_rdy[r] = c_rdy[rollback_id][r];
            end
            c_busy[rollback_id] = 1'b0;
        end else begin
            for (int k = 0; k < DW; k++) begin
                if (disp_valid[k] && (int'(dest_reg[k]) != ZREG)) begin
                    m_tag[dest_reg[k]] = int'(new_tag[k]);
                    m_rdy[dest_reg[k]] = 1'b0;
                end
                if (ckpt_req[k] && avail) begin
                    for (int r = 0; r < NAR; r++) begin
                        c_tag[slot][r] = m_tag[r];
                        c_rdy[slot][r] = m_rdy[r];
                    end
                    c_busy[slot] = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        reset        = 1'b0;
        en           = 1'b1;
        disp_valid   = '0;
        dest_reg     = '0;
        src_a        = '0;
        src_b        = '0;
        new_tag      = '0;
        ckpt_req     = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        rollback_en  = 1'b0;
        rollback_id  = '0;
        ckpt_release = '0;
    endtask

    task automatic do_cycle(input bit check);
        #2;
        if (check) check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        int pick;
        bit found;
        checks   = 0;
        failures = 0;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_cycle(1'b0);
        model_reset();

        // Reset state lookups.
        idle();
        src_a[0] = 5'd3; src_b[0] = 5'd5; dest_reg[0] = 5'd7;
        #1;
        chk("rst_t1", 32'(t1[0]), 32'd3);
        chk("rst_t2", 32'(t2[0]), 32'd5);
        chk("rst_t1_ready", 32'(t1_ready[0]), 32'd1);
        chk("rst_t2_ready", 32'(t2_ready[0]), 32'd1);
        chk("rst_told", 32'(told[0]), 32'd7);
        chk("rst_avail", 32'(ckpt_avail), 32'd1);
        chk("rst_id", 32'(ckpt_id), 32'd0);
        do_cycle(1'b1);

        // Intra-group bypass on the same destination.
        idle();
        disp_valid = 2'b11;
        dest_reg[0] = 5'd1; new_tag[0] = 6'd40;
        dest_reg[1] = 5'd1; new_tag[1] = 6'd41; src_a[1] = 5'd1;
        #1;
        chk("byp_t1", 32'(t1[1]), 32'd40);
        chk("byp_t1_ready", 32'(t1_ready[1]), 32'd0);
        chk("byp_told", 32'(told[1]), 32'd40);
        do_cycle(1'b1);
        idle();
        src_a[0] = 5'd1;
        #1;
        chk("byp_map_tag", 32'(t1[0]), 32'd41);
        chk("byp_map_ready", 32'(t1_ready[0]), 32'd0);
        do_cycle(1'b1);

        // CDB read bypass then wakeup of the map entry.
        idle();
        disp_valid[0] = 1'b1; dest_reg[0] = 5'd2; new_tag[0] = 6'd40;
        do_cycle(1'b1);
        idle();
        src_a[0] = 5'd2; cdb_valid = 2'b01; cdb_tag[0] = 6'd40;
        #1;
        chk("cdb_same_cycle_ready", 32'(t1_ready[0]), 32'd1);
        do_cycle(1'b1);
        idle();
        src_a[0] = 5'd2;
        #1;
        chk("cdb_next_ready", 32'(t1_ready[0]), 32'd1);
        do_cycle(1'b1);

        // Checkpoint on lane 1, younger rename, then rollback with CDB.
        idle();
        disp_valid = 2'b11; ckpt_req = 2'b10;
        dest_reg[0] = 5'd4; new_tag[0] = 6'd42;
        dest_reg[1] = 5'd6; new_tag[1] = 6'd43;
        #1;
        chk("ck_grant_id", 32'(ckpt_id), 32'd0);
        do_cycle(1'b1);
        idle();
        disp_valid[0] = 1'b1; dest_reg[0] = 5'd4; new_tag[0] = 6'd44;
        do_cycle(1'b1);
        idle();
        cdb_valid = 2'b01; cdb_tag[0] = 6'd42; rollback_en = 1'b1; rollback_id = 2'd0;
        do_cycle(1'b1);
        idle();
        src_a[0] = 5'd4; src_b[0] = 5'd6;
        #1;
        chk("rb_r4_tag", 32'(t1[0]), 32'd42);
        chk("rb_r4_ready", 32'(t1_ready[0]), 32'd1);
        chk("rb_r6_tag", 32'(t2[0]), 32'd43);
        chk("rb_r6_ready", 32'(t2_ready[0]), 32'd0);
        chk("rb_slot_free", 32'(ckpt_avail), 32'd1);
        chk("rb_slot_id", 32'(ckpt_id), 32'd0);
        do_cycle(1'b1);

        // Fill all four checkpoints, then release slot 2.
        for (int i = 0; i < NCK; i++) begin
            idle();
            disp_valid[0] = 1'b1; ckpt_req[0] = 1'b1;
            dest_reg[0] = 5'(10 + i); new_tag[0] = 6'(20 + i);
            #1;
            chk($sformatf("fill_id%0d", i), 32'(ckpt_id), 32'(i));
            do_cycle(1'b1);
        end
        idle();
        ckpt_release = 4'b0100;
        #1;
        chk("full_avail", 32'(ckpt_avail), 32'd0);
        do_cycle(1'b1);
        idle();
        #1;
        chk("rel_avail", 32'(ckpt_avail), 32'd1);
        chk("rel_id", 32'(ckpt_id), 32'd2);
        do_cycle(1'b1);
        idle();
        ckpt_release = 4'b1111;
        do_cycle(1'b1);

        // Writes to the zero register are dropped.
        idle();
        disp_valid[0] = 1'b1; dest_reg[0] = 5'd31; new_tag[0] = 6'd50; src_a[0] = 5'd31;
        #1;
        chk("zero_t1", 32'(t1[0]), 32'd31);
        chk("zero_ready", 32'(t1_ready[0]), 32'd1);
        chk("zero_told", 32'(told[0]), 32'd31);
        do_cycle(1'b1);
        idle();
        dest_reg[0] = 5'd31;
        #1;
        chk("zero_told_after", 32'(told[0]), 32'd31);
        do_cycle(1'b1);

        // Enable low freezes state, including CDB.
        idle();
        en = 1'b0; disp_valid[0] = 1'b1; dest_reg[0] = 5'd8; new_tag[0] = 6'd55;
        cdb_valid = 2'b01; cdb_tag[0] = 6'd41;
        do_cycle(1'b1);
        idle();
        src_a[0] = 5'd8; src_b[0] = 5'd1;
        #1;
        chk("en_low_r8", 32'(t1[0]), 32'd8);
        chk("en_low_r1_ready", 32'(t2_ready[0]), 32'd0);
        do_cycle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            idle();
            reset = (i == 200);
            en = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < DW; k++) begin
                disp_valid[k] = 1'($urandom_range(0, 1));
                dest_reg[k]   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                src_a[k]      = 5'($urandom_range(0, 31));
                src_b[k]      = ($urandom_range(0, 3) == 0) ? dest_reg[0] : 5'($urandom_range(0, 31));
                new_tag[k]    = 6'($urandom_range(0, 63));
            end
            for (int c = 0; c < CW; c++) begin
                cdb_valid[c] = 1'($urandom_range(0, 1));
                cdb_tag[c]   = 6'($urandom_range(0, 63));
            end
            if (any_free() && ($urandom_range(0, 3) == 0)) begin
                pick = $urandom_range(0, DW - 1);
                ckpt_req[pick]   = 1'b1;
                disp_valid[pick] = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                pick  = $urandom_range(0, NCK - 1);
                found = 1'b0;
                for (int t = 0; t < NCK; t++) begin
                    if (!found && c_busy[(pick + t) % NCK]) begin
                        rollback_id = 2'((pick + t) % NCK);
                        found = 1'b1;
                    end
                end
                rollback_en = found;
            end
            if ($urandom_range(0, 5) == 0) begin
                for (int s = 0; s < NCK; s++) ckpt_release[s] = c_busy[s] & 1'($urandom_range(0, 1));
            end
            do_cycle(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
